// File: rtl/ot_pkg.sv
// rtl/ot_pkg.sv - shared state encoding and default operand width for the OT sender controller
package ot_pkg;
   localparam int OT_W = 32;

   typedef enum logic [2:0] {
      S_RXCFG  = 3'd0,
      S_GEN    = 3'd1,
      S_TXRAND = 3'd2,
      S_RXV    = 3'd3,
      S_PACK   = 3'd4,
      S_TXPACK = 3'd5
   } ot_state_t;
endpackage

// File: rtl/ot_tx_serializer.sv
// rtl/ot_tx_serializer.sv - two-operand byte serializer, MSB-first, one byte per accepted transfer
module ot_tx_serializer
   import ot_pkg::*;
#(
   parameter int W = OT_W
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           load,
   input  logic           shift,
   input  logic [2*W-1:0] load_data,
   output logic [7:0]     byte_data
);
   logic [2*W-1:0] sh;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         sh <= '0;
      else if (load)
         sh <= load_data;
      else if (shift)
         sh <= sh << 8;
   end

   // The byte on the wire only moves when the host accepts it, so it holds through stalls.
   assign byte_data = sh[2*W-1 -: 8];
endmodule

// File: rtl/ot_sender_ctrl.sv
// rtl/ot_sender_ctrl.sv - OT sender session sequencer: config rx, RNG, rand tx, v rx, pack, packed tx
module ot_sender_ctrl
   import ot_pkg::*;
#(
   parameter int W = OT_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         rx_valid,
   output logic         rx_ready,
   input  logic [7:0]   rx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [7:0]   tx_data,
   output logic [W-1:0] N,
   output logic [W-1:0] d,
   output logic [W-1:0] message0,
   output logic [W-1:0] message1,
   output logic [W-1:0] received_data,
   output logic         rng_gen,
   input  logic         rng_end0,
   input  logic         rng_end1,
   input  logic [W-1:0] rand_val0,
   input  logic [W-1:0] rand_val1,
   output logic         pack_gen,
   input  logic         pack_end,
   input  logic [W-1:0] packed_data0,
   input  logic [W-1:0] packed_data1,
   output logic         busy
);
   localparam int NB = W / 8;
   localparam int CW = $clog2(4 * NB);

   ot_state_t      state, state_nx;
   logic [CW-1:0]  cnt;
   logic           end0_f, end1_f, gen_done;
   logic           rx_ready_c, rx_fire, tx_fire;
   logic           ser_load, ser_sel_pack;
   logic [4*W-1:0] cfg_sh;
   logic [W-1:0]   rxv_sh;

   assign gen_done = (end0_f | rng_end0) & (end1_f | rng_end1);
   assign rx_fire  = rx_valid & rx_ready_c;
   assign tx_fire  = tx_valid & tx_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= S_RXCFG;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      rx_ready_c   = 1'b0;
      tx_valid     = 1'b0;
      rng_gen      = 1'b0;
      pack_gen     = 1'b0;
      ser_load     = 1'b0;
      ser_sel_pack = 1'b0;
      case (state)
         S_RXCFG: begin
            rx_ready_c = 1'b1;
            if (rx_fire && cnt == CW'(4 * NB - 1)) state_nx = S_GEN;
         end
         S_GEN: begin
            rng_gen = (cnt == '0);
            if (gen_done) begin
               ser_load = 1'b1;
               state_nx = S_TXRAND;
            end
         end
         S_TXRAND: begin
            tx_valid = 1'b1;
            if (tx_fire && cnt == CW'(2 * NB - 1)) state_nx = S_RXV;
         end
         S_RXV: begin
            rx_ready_c = 1'b1;
            if (rx_fire && cnt == CW'(NB - 1)) state_nx = S_PACK;
         end
         S_PACK: begin
            pack_gen     = (cnt == '0);
            ser_sel_pack = 1'b1;
            if (pack_end) begin
               ser_load = 1'b1;
               state_nx = S_TXPACK;
            end
         end
         S_TXPACK: begin
            tx_valid = 1'b1;
            if (tx_fire && cnt == CW'(2 * NB - 1)) state_nx = S_RXCFG;
         end
         default: state_nx = S_RXCFG;
      endcase
   end

   // The counter also steps once after a start pulse, so the pulse cannot repeat within a state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (state_nx != state)
         cnt <= '0;
      else if (rx_fire || tx_fire || rng_gen || pack_gen)
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         end0_f <= 1'b0;
         end1_f <= 1'b0;
      end else if (state != S_GEN) begin
         end0_f <= 1'b0;
         end1_f <= 1'b0;
      end else begin
         end0_f <= end0_f | rng_end0;
         end1_f <= end1_f | rng_end1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cfg_sh <= '0;
         rxv_sh <= '0;
      end else if (rx_fire) begin
         if (state == S_RXCFG)
            cfg_sh <= (cfg_sh << 8) | (4 * W)'(rx_data);
         else
            rxv_sh <= (rxv_sh << 8) | W'(rx_data);
      end
   end

   assign N             = cfg_sh[4*W-1 -: W];
   assign d             = cfg_sh[3*W-1 -: W];
   assign message0      = cfg_sh[2*W-1 -: W];
   assign message1      = cfg_sh[W-1:0];
   assign received_data = rxv_sh;
   assign rx_ready      = rx_ready_c & rstn;
   assign busy          = (state != S_RXCFG);

   ot_tx_serializer #(.W(W)) u_ser (
      .clk       (clk),
      .rstn      (rstn),
      .load      (ser_load),
      .shift     (tx_fire),
      .load_data (ser_sel_pack ? {packed_data0, packed_data1} : {rand_val0, rand_val1}),
      .byte_data (tx_data)
   );
endmodule

// File: tb/tb_ot_sender_ctrl.sv
// tb/tb_ot_sender_ctrl.sv - randomized bench for ot_sender_ctrl against a transaction-level session model
module tb_ot_sender_ctrl;
   localparam int W = 32;
   localparam int P_CFG = 0, P_GEN = 1, P_TXR = 2, P_RXV = 3, P_PACK = 4, P_TXP = 5;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         rx_valid = 1'b0, rx_ready;
   logic [7:0]   rx_data = '0;
   logic         tx_valid, tx_ready = 1'b0;
   logic [7:0]   tx_data;
   logic [W-1:0] N, d, message0, message1, received_data;
   logic         rng_gen, rng_end0 = 1'b0, rng_end1 = 1'b0;
   logic [W-1:0] rand_val0 = '0, rand_val1 = '0;
   logic         pack_gen, pack_end = 1'b0;
   logic [W-1:0] packed_data0 = '0, packed_data1 = '0;
   logic         busy;

   always #5 clk = ~clk;

   ot_sender_ctrl #(.W(W)) dut (
      .clk(clk), .rstn(rstn),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .N(N), .d(d), .message0(message0), .message1(message1), .received_data(received_data),
      .rng_gen(rng_gen), .rng_end0(rng_end0), .rng_end1(rng_end1),
      .rand_val0(rand_val0), .rand_val1(rand_val1),
      .pack_gen(pack_gen), .pack_end(pack_end),
      .packed_data0(packed_data0), .packed_data1(packed_data1),
      .busy(busy)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Session model: phase, bytes seen in the phase, and the bytes still owed on tx.
   int           m_phase, m_cnt;
   bit           m_first, m_seen0, m_seen1;
   logic [7:0]   m_q[$];
   logic [7:0]   m_cfg[16];
   logic [W-1:0] m_n, m_d, m_m0, m_m1, m_rv;

   task automatic m_enter(input int p);
      m_phase = p;
      m_cnt   = 0;
      m_first = 1'b1;
   endtask

   task automatic m_push(input logic [W-1:0] v);
      for (int i = W / 8 - 1; i >= 0; i--) m_q.push_back(v[8*i +: 8]);
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         m_phase = P_CFG; m_cnt = 0; m_first = 1'b0;
         m_seen0 = 1'b0; m_seen1 = 1'b0; m_q.delete();
         m_n = '0; m_d = '0; m_m0 = '0; m_m1 = '0; m_rv = '0;
         chk("rst_rx_ready", rx_ready, 1'b0);
         chk("rst_tx_valid", tx_valid, 1'b0);
         chk("rst_rng_gen", rng_gen, 1'b0);
         chk("rst_pack_gen", pack_gen, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_tx_data", tx_data, 8'h00);
         chk("rst_operands", {N, d, message0, message1, received_data} == '0, 1'b1);
      end else begin
         chk("rx_ready", rx_ready, (m_phase == P_CFG || m_phase == P_RXV));
         chk("tx_valid", tx_valid, (m_phase == P_TXR || m_phase == P_TXP));
         chk("busy", busy, (m_phase != P_CFG));
         chk("rng_gen", rng_gen, (m_phase == P_GEN && m_first));
         chk("pack_gen", pack_gen, (m_phase == P_PACK && m_first));
         if (m_phase != P_CFG) begin
            chk("N", N, m_n);
            chk("d", d, m_d);
            chk("message0", message0, m_m0);
            chk("message1", message1, m_m1);
         end
         if (m_phase != P_RXV) chk("received_data", received_data, m_rv);
         if (m_phase == P_TXR || m_phase == P_TXP) begin
            if (m_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL tx_queue: DUT sending, model owes no byte at %0t", $time);
            end else begin
               chk("tx_data", tx_data, m_q[0]);
            end
         end
         case (m_phase)
            P_CFG: if (rx_valid) begin
               m_cfg[m_cnt] = rx_data;
               m_cnt++;
               if (m_cnt == 16) begin
                  m_n  = {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]};
                  m_d  = {m_cfg[4], m_cfg[5], m_cfg[6], m_cfg[7]};
                  m_m0 = {m_cfg[8], m_cfg[9], m_cfg[10], m_cfg[11]};
                  m_m1 = {m_cfg[12], m_cfg[13], m_cfg[14], m_cfg[15]};
                  m_seen0 = 1'b0; m_seen1 = 1'b0;
                  m_enter(P_GEN);
               end
            end
            P_GEN: begin
               m_first = 1'b0;
               m_seen0 = m_seen0 | rng_end0;
               m_seen1 = m_seen1 | rng_end1;
               if (m_seen0 && m_seen1) begin
                  m_push(rand_val0); m_push(rand_val1);
                  m_enter(P_TXR);
               end
            end
            P_TXR, P_TXP: if (tx_ready) begin
               if (m_q.size() > 0) void'(m_q.pop_front());
               m_cnt++;
               if (m_cnt == 8) m_enter(m_phase == P_TXR ? P_RXV : P_CFG);
            end
            P_RXV: if (rx_valid) begin
               m_rv = {m_rv[W-9:0], rx_data};
               m_cnt++;
               if (m_cnt == 4) m_enter(P_PACK);
            end
            P_PACK: begin
               m_first = 1'b0;
               if (pack_end) begin
                  m_push(packed_data0); m_push(packed_data1);
                  m_enter(P_TXP);
               end
            end
            default: ;
         endcase
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_inputs(input bit full);
      rx_valid     = full ? 1'b1 : ($urandom_range(3) != 0);
      tx_ready     = full ? 1'b1 : ($urandom_range(3) != 0);
      rx_data      = 8'($urandom);
      rng_end0     = ($urandom_range(5) == 0);
      rng_end1     = ($urandom_range(5) == 0);
      pack_end     = ($urandom_range(4) == 0);
      rand_val0    = $urandom;
      rand_val1    = $urandom;
      packed_data0 = $urandom;
      packed_data1 = $urandom;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   logic [7:0] cfgb[16];
   logic [7:0] rnd_exp[8];
   logic [7:0] pk_exp[8];
   int got;

   initial begin
      cfgb    = '{8'h00, 8'h00, 8'h00, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h11,
                  8'h00, 8'h00, 8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h42};
      rnd_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      pk_exp  = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02, 8'h03, 8'h04};

      repeat (3) cyc();
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_rx_ready", rx_ready, 1'b1);
      cyc();
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_data = cfgb[i];
         cyc();
      end
      rx_valid  = 1'b0;
      rand_val0 = 32'h12345678;
      rand_val1 = 32'h9ABCDEF0;
      @(negedge clk);
      chk("cfg_N", N, 32'hBB);
      chk("cfg_d", d, 32'h11);
      chk("cfg_m0", message0, 32'h41);
      chk("cfg_m1", message1, 32'h42);
      chk("rng_gen_first", rng_gen, 1'b1);
      cyc();
      @(negedge clk);
      chk("rng_gen_single", rng_gen, 1'b0);
      cyc(); rng_end1 = 1'b1;
      cyc(); rng_end1 = 1'b0;
      cyc();
      cyc(); rng_end0 = 1'b1;
      @(negedge clk);
      chk("gen_wait_tx_valid", tx_valid, 1'b0);
      cyc(); rng_end0 = 1'b0; tx_ready = 1'b1; pack_end = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("txrand_valid", tx_valid, 1'b1);
         chk("txrand_byte", tx_data, rnd_exp[i]);
         cyc();
         pack_end = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         rx_valid = 1'b1; rx_data = 8'h00;
         cyc();
      end
      rx_valid = 1'b0; rx_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rxv_stall_data", received_data, 32'h0);
         cyc();
      end
      rx_valid = 1'b1; rx_data = 8'h01;
      @(negedge clk);
      chk("rxv_before_last", received_data, 32'h0);
      cyc(); rx_valid = 1'b0;
      @(negedge clk);
      chk("rxv_after_last", received_data, 32'h1);
      chk("pack_gen_first", pack_gen, 1'b1);
      cyc();
      @(negedge clk);
      chk("pack_gen_single", pack_gen, 1'b0);
      chk("pack_waits_fresh_end", tx_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         chk("pack_wait_busy", busy, 1'b1);
      end
      cyc();
      packed_data0 = 32'hCAFEBABE; packed_data1 = 32'h01020304; pack_end = 1'b1;
      cyc(); pack_end = 1'b0;
      got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         tx_ready = (c % 2 == 1);
         @(negedge clk);
         chk("txpack_byte", tx_data, pk_exp[got]);
         if (tx_valid && tx_ready) got++;
         cyc();
      end
      chk("txpack_count", got, 8);
      tx_ready = 1'b0;
      @(negedge clk);
      chk("idle_rx_ready", rx_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);

      // Random traffic up to S_PACK, then a reset with a stray pack_end.
      cyc();
      for (int c = 0; c < 600 && m_phase != P_PACK; c++) begin
         rnd_inputs(1'b0);
         pack_end = 1'b0;
         cyc();
      end
      chk("reach_pack_busy", busy, 1'b1);
      chk("reach_pack_no_tx", tx_valid, 1'b0);
      rstn = 1'b0; pack_end = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
      @(negedge clk);
      chk("abort_rx_ready", rx_ready, 1'b0);
      chk("abort_tx_valid", tx_valid, 1'b0);
      chk("abort_pack_gen", pack_gen, 1'b0);
      chk("abort_busy", busy, 1'b0);
      cyc();
      cyc(); rstn = 1'b1;
      @(negedge clk);
      chk("abort_stray_busy", busy, 1'b0);
      chk("abort_stray_pack_gen", pack_gen, 1'b0);
      chk("abort_stray_rx_ready", rx_ready, 1'b1);
      cyc(); pack_end = 1'b0;

      for (int c = 0; c < 5000; c++) begin
         rnd_inputs(((c / 200) % 3) == 1);
         rstn = ($urandom_range(700) != 0);
         cyc();
      end
      rstn = 1'b1;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ot_sender_ctrl.md
OT_SENDER_CTRL -- requirements
Module: ot_sender_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, operand width in bits; must be a multiple of 8; NB = W/8 bytes per operand.
REQ-002 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-003 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_valid, input, 1, host byte valid.
REQ-005 SHALL have port rx_ready, output, 1, controller accepts a byte.
REQ-006 SHALL have port rx_data, input, 8, host byte.
REQ-007 SHALL have port tx_valid, output, 1, controller byte valid.
REQ-008 SHALL have port tx_ready, input, 1, host accepts a byte.
REQ-009 SHALL have port tx_data, output, 8, controller byte.
REQ-010 SHALL have ports N, d, message0, message1, received_data, all output, W, registered operands driven to the RNGs and the RSA packer.
REQ-011 SHALL have ports rng_gen (output, 1) and rng_end0/rng_end1 (input, 1), the start pulse to both RNGs and their done strobes.
REQ-012 SHALL have ports rand_val0 and rand_val1, both input, W, the RNG results.
REQ-013 SHALL have ports pack_gen (output, 1) and pack_end (input, 1), the packer start pulse and its done strobe.
REQ-014 SHALL have ports packed_data0 and packed_data1, both input, W, the packer results.
REQ-015 SHALL have port busy, output, 1, high in every state except S_RXCFG.

Function
REQ-016 SHALL implement FSM S_RXCFG -> S_GEN -> S_TXRAND -> S_RXV -> S_PACK -> S_TXPACK -> S_RXCFG.
REQ-017 SHALL transfer an rx byte only when rx_valid && rx_ready; a tx byte only when tx_valid && tx_ready.
REQ-018 SHALL drive rx_ready high only in S_RXCFG and S_RXV, and tx_valid high only in S_TXRAND and S_TXPACK.
REQ-019 SHALL load all multi-byte operands MSB-first and transmit them MSB-first.
REQ-020 S_RXCFG SHALL accept 4*NB bytes into N, d, message0, message1 (in that order), then enter S_GEN.
REQ-021 S_GEN SHALL assert rng_gen for exactly its first cycle, then latch rng_end0 and rng_end1 as separate sticky flags.
REQ-022 S_GEN SHALL, in the cycle both flags are set (same-cycle ends included), capture rand_val0 and rand_val1 into the tx shifter and enter S_TXRAND.
REQ-023 S_TXRAND SHALL send 2*NB bytes, rand0 then rand1, then enter S_RXV.
REQ-024 S_RXV SHALL accept NB bytes into received_data, then enter S_PACK.
REQ-025 S_PACK SHALL assert pack_gen for exactly its first cycle; on pack_end it SHALL capture packed_data0 and packed_data1 and enter S_TXPACK.
REQ-026 S_TXPACK SHALL send 2*NB bytes, packed0 then packed1, then return to S_RXCFG.
REQ-027 SHALL hold tx_data stable while tx_valid && !tx_ready.
REQ-028 SHALL use a single shared byte counter that clears on every state change; the last byte of a phase and the state transition occur on the same edge.
REQ-029 SHALL ignore rng_end*/pack_end outside S_GEN/S_PACK; sticky end flags SHALL clear on entry to S_GEN.
REQ-030 SHALL accept one rx byte per cycle with no bubble when rx_valid is held high.
REQ-031 SHALL send one tx byte per cycle with no bubble when tx_ready is held high.

Reset
REQ-032 On rstn low, SHALL asynchronously enter S_RXCFG and clear all of the following: counter, end flags, shifter, N, d, message0, message1, received_data.
REQ-033 During reset, SHALL hold rx_ready, tx_valid, rng_gen, pack_gen and busy at 0 and tx_data at 0x00.
REQ-034 SHALL raise rx_ready in the first cycle after rstn deasserts.
REQ-035 A reset in any state SHALL abort the session; no pulse SHALL be reissued until its state is re-entered.

Structure
REQ-036 State encoding and the default W SHALL live in shared package ot_pkg.
REQ-037 The tx byte serializer (2*W load, shift 8 per accepted byte) SHALL be sub-module ot_tx_serializer.

Verification
REQ-038 W=32, rx stream 00000xBB,00000011,00000041,00000042 with no stalls -> N=0xBB, d=0x11, m0=0x41, m1=0x42 after 16 rx cycles; rng_gen single pulse next cycle.
REQ-039 rng_end1 3 cycles before rng_end0, rand0=0x12345678, rand1=0x9ABCDEF0 -> tx 12,34,56,78,9A,BC,DE,F0 after rng_end0.
REQ-040 tx_ready toggled 1/0 each cycle in S_TXPACK -> tx_data constant during stalls, 8 bytes total, then rx_ready=1 and busy=0.
REQ-041 rx_valid low 5 cycles mid-S_RXV, v=0x00000001 -> received_data=1 only after 4th byte; pack_gen one cycle.
REQ-042 rstn pulsed low in S_PACK -> next-cycle rx_ready=0, tx_valid=0, pack_gen=0, busy=0; stray pack_end afterwards ignored.
REQ-043 pack_end asserted during S_TXRAND -> no effect; S_PACK still waits for a fresh pack_end.
